cmt_trace_fifo: RTL and testbench

- Verification-side commit trace buffer that sits between the core's per-lane commit outputs and the testbench checker.
- Each cycle it packs up to LANES commit records, in lane order, into a circular buffer.
- It stamps each record with a global sequence number and drains one record per cycle over a valid/ready handshake.
- It raises a high-watermark stall request toward the core's sync logic and reports lost records through a sticky overflow flag and a drop counter.

---
 rtl/cmt_trace_fifo.sv | 167 ++++++++++++++++
 tb/tb_cmt_trace_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmt_trace_fifo.sv
// rtl/cmt_trace_fifo.sv - commit trace buffer: packs per-lane commits, stamps sequence numbers, drains one per cycle.
// Defining CMT_TRACE_TS_EN stores a push-cycle timestamp with every record and exposes it on out_ts.
module cmt_trace_fifo #(
  parameter int LANES = 4,
  parameter int DEPTH = 64,
  parameter int XLEN  = 64,
  parameter int HIWAT = DEPTH - 2 * LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [LANES-1:0]         in_valid,
  input  logic [LANES*XLEN-1:0]    in_pc,
  input  logic [LANES*32-1:0]      in_ir,
  input  logic [LANES-1:0]         in_rdw,
  input  logic [LANES*6-1:0]       in_rda,
  input  logic [LANES*XLEN-1:0]    in_rdv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_ir,
  output logic                     out_rdw,
  output logic [5:0]               out_rda,
  output logic [XLEN-1:0]          out_rdv,
  output logic [63:0]              out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     stall,
  output logic                     overflow,
`ifdef CMT_TRACE_TS_EN
  output logic [63:0]              out_ts,
`endif
  output logic [31:0]              drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem_pc  [DEPTH];
  logic [31:0]     mem_ir  [DEPTH];
  logic            mem_rdw [DEPTH];
  logic [5:0]      mem_rda [DEPTH];
  logic [XLEN-1:0] mem_rdv [DEPTH];
  logic [63:0]     mem_seq [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   seq_q, seq_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   drops_q, drops_d;

  logic [CW-1:0] n_c;
  logic [CW-1:0] free_c;
  logic [AW-1:0] off_c  [LANES];
  logic [AW-1:0] slot_c [LANES];
  logic          push_ok;
  logic          push_drop;
  logic          pop;
  logic [32:0]   drop_sum;

  // Each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    n_c = '0;
    for (int i = 0; i < LANES; i++) begin
      off_c[i]  = n_c[AW-1:0];
      slot_c[i] = wptr_q + n_c[AW-1:0];
      n_c       = n_c + CW'(in_valid[i]);
    end
  end

  always_comb begin
    free_c    = CW'(DEPTH) - count_q;
    push_ok   = (n_c != '0) && (n_c <= free_c) && !flush;
    push_drop = (n_c > free_c) && !flush;
    out_valid = (count_q != '0) && !rst;
    pop       = out_valid && out_ready && !flush;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + n_c[AW-1:0];
      if (pop)     rptr_d = rptr_q + AW'(1);
      count_d = count_q + (push_ok ? n_c : '0) - CW'(pop);
    end

    seq_d    = seq_q + 64'(n_c);
    drop_sum = {1'b0, drops_q} + 33'(n_c);
    drops_d  = drops_q;
    if (push_drop) drops_d = drop_sum[32] ? '1 : drop_sum[31:0];
    ovf_d   = ovf_q | push_drop;
    stall_d = (count_d >= CW'(HIWAT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  // Storage is deliberately unreset; pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) begin
          mem_pc[slot_c[i]]  <= in_pc[i*XLEN +: XLEN];
          mem_ir[slot_c[i]]  <= in_ir[i*32 +: 32];
          mem_rdw[slot_c[i]] <= in_rdw[i];
          mem_rda[slot_c[i]] <= in_rda[i*6 +: 6];
          mem_rdv[slot_c[i]] <= in_rdv[i*XLEN +: XLEN];
          mem_seq[slot_c[i]] <= seq_q + 64'(off_c[i]);
        end
      end
    end
  end

`ifdef CMT_TRACE_TS_EN
  logic [63:0] ts_q;
  logic [63:0] mem_ts [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) mem_ts[slot_c[i]] <= ts_q;
      end
    end
  end

  assign out_ts = mem_ts[rptr_q];
`endif

  assign out_pc   = mem_pc[rptr_q];
  assign out_ir   = mem_ir[rptr_q];
  assign out_rdw  = mem_rdw[rptr_q];
  assign out_rda  = mem_rda[rptr_q];
  assign out_rdv  = mem_rdv[rptr_q];
  assign out_seq  = mem_seq[rptr_q];
  assign count    = count_q;
  assign stall    = stall_q;
  assign overflow = ovf_q;
  assign drops    = drops_q;

endmodule

// File: tb/tb_cmt_trace_fifo.sv
// tb/tb_cmt_trace_fifo.sv - directed-vector bench for cmt_trace_fifo at LANES=4, DEPTH=64, XLEN=64.
module tb_cmt_trace_fifo;

  localparam int LANES = 4;
  localparam int DEPTH = 64;
  localparam int XLEN  = 64;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic [LANES-1:0]        in_valid;
  logic [LANES*XLEN-1:0]   in_pc;
  logic [LANES*32-1:0]     in_ir;
  logic [LANES-1:0]        in_rdw;
  logic [LANES*6-1:0]      in_rda;
  logic [LANES*XLEN-1:0]   in_rdv;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_ir;
  logic                    out_rdw;
  logic [5:0]              out_rda;
  logic [XLEN-1:0]         out_rdv;
  logic [63:0]             out_seq;
  logic [$clog2(DEPTH):0]  count;
  logic                    stall;
  logic                    overflow;
  logic [31:0]             drops;
`ifdef CMT_TRACE_TS_EN
  logic [63:0]             out_ts;
`endif

  int vectors;
  int miscompares;

  cmt_trace_fifo #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir), .in_rdw(in_rdw),
    .in_rda(in_rda), .in_rdv(in_rdv),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
    .out_rdw(out_rdw), .out_rda(out_rda), .out_rdv(out_rdv), .out_seq(out_seq),
    .count(count), .stall(stall), .overflow(overflow),
`ifdef CMT_TRACE_TS_EN
    .out_ts(out_ts),
`endif
    .drops(drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_pc(input int lane, input logic [63:0] pc);
    in_pc[lane*XLEN +: XLEN] = pc;
  endtask

  task automatic pop_expect(input string tag, input logic [63:0] pc, input logic [63:0] seq);
    in_valid  = '0;
    out_ready = 1'b1;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".seq"}, out_seq, seq);
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    in_pc  = '0;
    in_ir  = '0;
    in_rdw = '0;
    in_rda = '0;
    in_rdv = '0;
    do_reset();
    step();
    check("rst.count", 64'(count), 64'd0);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.stall", 64'(stall), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.drops", 64'(drops), 64'd0);

    // Single-lane pushes, then drain in order
    in_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      set_pc(0, 64'h10 + 64'(k));
      if (k == 0) check("single.valid_before", 64'(out_valid), 64'd0);
      step();
      if (k == 0) check("single.valid_after", 64'(out_valid), 64'd1);
    end
    in_valid = '0;
    check("single.count", 64'(count), 64'd3);
    for (int k = 0; k < 3; k++) pop_expect("single", 64'h10 + 64'(k), 64'(k));
    check("single.empty", 64'(count), 64'd0);

    // Sparse lanes 1 and 3
    do_reset();
    set_pc(0, 64'hdead);
    set_pc(1, 64'h100);
    set_pc(2, 64'hdead);
    set_pc(3, 64'h300);
    in_ir[3*32 +: 32]     = 32'h0050_0513;
    in_rdw[3]             = 1'b1;
    in_rda[3*6 +: 6]      = 6'd5;
    in_rdv[3*XLEN +: XLEN] = 64'habc;
    in_valid = 4'b1010;
    step();
    in_valid = '0;
    check("sparse.count", 64'(count), 64'd2);
    pop_expect("sparse0", 64'h100, 64'd0);
    check("sparse1.ir", 64'(out_ir), 64'h0050_0513);
    check("sparse1.rdw", 64'(out_rdw), 64'd1);
    check("sparse1.rda", 64'(out_rda), 64'd5);
    check("sparse1.rdv", out_rdv, 64'habc);
    pop_expect("sparse1", 64'h300, 64'd1);

    // Fill to full, stall threshold, dropped group
    do_reset();
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < LANES; i++) set_pc(i, 64'h2000 + 64'(4 * k + i));
      in_valid = 4'hF;
      step();
      if (k == 12) check("fill.stall_52", 64'(stall), 64'd0);
      if (k == 13) check("fill.stall_56", 64'(stall), 64'd1);
      if (k == 15) begin
        check("fill.count_full", 64'(count), 64'd64);
        check("fill.ovf_before", 64'(overflow), 64'd0);
      end
    end
    in_valid = '0;
    check("fill.count_after_drop", 64'(count), 64'd64);
    check("fill.ovf", 64'(overflow), 64'd1);
    check("fill.drops", 64'(drops), 64'd4);
    pop_expect("fill.head", 64'h2000, 64'd0);
    out_ready = 1'b0;
    set_pc(0, 64'h2000 + 64'd68);
    in_valid = 4'b0001;
    step();
    in_valid = '0;
    check("fill.count_refill", 64'(count), 64'd64);
    for (int i = 1; i < 64; i++) pop_expect("fill.drain", 64'h2000 + 64'(i), 64'(i));
    pop_expect("fill.gap", 64'h2000 + 64'd68, 64'd68);
    check("fill.empty", 64'(count), 64'd0);
    check("fill.stall_clear", 64'(stall), 64'd0);

    // Flush with same-cycle push, overflow and drops preserved
    out_ready = 1'b0;
    in_valid = 4'hF; step();
    in_valid = 4'hF; step();
    in_valid = 4'h3; step();
    check("flush.count_pre", 64'(count), 64'd10);
    flush = 1'b1;
    in_valid = 4'h3;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    check("flush.count", 64'(count), 64'd0);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.ovf", 64'(overflow), 64'd1);
    check("flush.drops", 64'(drops), 64'd4);
    set_pc(0, 64'h555);
    in_valid = 4'b0001;
    step();
    in_valid = '0;
    check("flush.count_post", 64'(count), 64'd1);
    check("flush.next_seq", out_seq, 64'd81);
    check("flush.next_pc", out_pc, 64'h555);

    // Reset mid-drain clears buffer, counters and sequence
    in_valid = 4'hF;
    step();
    in_valid = '0;
    check("rstmid.count_pre", 64'(count), 64'd5);
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    check("rstmid.count", 64'(count), 64'd0);
    check("rstmid.valid", 64'(out_valid), 64'd0);
    check("rstmid.drops", 64'(drops), 64'd0);
    check("rstmid.ovf", 64'(overflow), 64'd0);
    set_pc(0, 64'h777);
    in_valid = 4'b0001;
    step();
    in_valid = '0;
    check("rstmid.seq", out_seq, 64'd0);
    check("rstmid.pc", out_pc, 64'h777);

    // Pointer wrap: walk both pointers to slot 62, then a 4-lane group straddles the end
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = (k < 15) ? 4'hF : 4'h3;
      step();
    end
    in_valid = '0;
    for (int c = 0; c < 200 && count != '0; c++) step();
    check("wrap.drained", 64'(count), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < LANES; i++) set_pc(i, 64'hA0 + 64'(i));
    in_valid = 4'hF;
    step();
    in_valid = '0;
    check("wrap.count", 64'(count), 64'd4);
    for (int i = 0; i < LANES; i++) pop_expect("wrap", 64'hA0 + 64'(i), 64'd62 + 64'(i));
    check("wrap.empty", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
